// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch unit and the control FSM: widths, opcodes,
// instruction field positions and the fetch state encoding.
package instr_fetch_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OP1_MSB = 11;
    localparam int unsigned OP1_LSB = 8;
    localparam int unsigned OP2_MSB = 7;
    localparam int unsigned OP2_LSB = 4;
    localparam int unsigned OP3_MSB = 3;
    localparam int unsigned OP3_LSB = 0;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_ADDI  = 4'd8;
    localparam logic [3:0] OP_SUBI  = 4'd9;
    localparam logic [3:0] OP_LOAD  = 4'd10;
    localparam logic [3:0] OP_STORE = 4'd11;
    localparam logic [3:0] OP_BLT   = 4'd12;
    localparam logic [3:0] OP_BGE   = 4'd13;
    localparam logic [3:0] OP_BEQ   = 4'd14;
    localparam logic [3:0] OP_JUMP  = 4'd15;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: redirect load has priority over increment; increment wraps
// naturally at 2^ADDR_W.
module instr_fetch_pc_reg #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding read, holds the decoded word until the
// control FSM accepts it, and drops any word made stale by a redirect.
module instr_fetch #(
    parameter int unsigned ADDR_W  = instr_fetch_pkg::ADDR_W,
    parameter int unsigned INSTR_W = instr_fetch_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [3:0]         op_code,
    output logic [3:0]         op1,
    output logic [3:0]         op2,
    output logic [3:0]         op3,
    output logic [15:0]        imm,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    import instr_fetch_pkg::*;

    fetch_state_e       r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_discard;

    logic [ADDR_W-1:0]  w_pc;
    logic               w_pc_load;
    logic               w_pc_inc;

    // A redirect retargets the pc in every state; only an accepted word advances it.
    always_comb begin
        w_pc_load = redirect;
        w_pc_inc  = (r_state == StWait) && imem_valid && !r_discard && !redirect;
    end

    instr_fetch_pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_pc_load),
        .i_load_val (redirect_pc),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StReq;
            r_ir       <= '0;
            r_instr_pc <= '0;
            r_discard  <= 1'b0;
        end else begin
            unique case (r_state)
                StReq: begin
                    r_state <= redirect ? StReq : StWait;
                end
                StWait: begin
                    if (imem_valid) begin
                        if (r_discard || redirect) begin
                            r_discard <= 1'b0;
                            r_state   <= StReq;
                        end else begin
                            r_ir       <= imem_data;
                            r_instr_pc <= w_pc;
                            r_state    <= StHold;
                        end
                    end else if (redirect) begin
                        // Read still in flight: remember to throw its data away.
                        r_discard <= 1'b1;
                    end
                end
                StHold: begin
                    if (redirect || instr_ready) begin
                        r_state <= StReq;
                    end
                end
                default: begin
                    r_state <= StReq;
                end
            endcase
        end
    end

    // Gated by reset so no read request escapes while reset is held.
    assign imem_rd     = (r_state == StReq) && !reset;
    assign imem_addr   = w_pc;
    assign instr_valid = (r_state == StHold);
    assign op_code     = r_ir[OPC_MSB:OPC_LSB];
    assign op1         = r_ir[OP1_MSB:OP1_LSB];
    assign op2         = r_ir[OP2_MSB:OP2_LSB];
    assign op3         = r_ir[OP3_MSB:OP3_LSB];
    assign imm         = sext4(r_ir[OP1_MSB:OP1_LSB]);
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs driven and outputs sampled on the
// falling clock edge, expected values written out by hand.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  op_code;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [3:0]  op3;
    logic [15:0] imm;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W  (16),
        .INSTR_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op_code     (op_code),
        .op1         (op1),
        .op2         (op2),
        .op3         (op3),
        .imm         (imm),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Starts in a REQ cycle, answers after lat cycles, returns in the first HOLD cycle.
    task automatic fetch(input logic [15:0] addr, input logic [15:0] data, input int lat);
        chk("req_rd", 32'(imem_rd), 32'h1);
        chk("req_addr", 32'(imem_addr), 32'(addr));
        for (int i = 1; i <= lat; i++) begin
            step();
            imem_valid = (i == lat);
            imem_data  = (i == lat) ? data : 16'h0000;
            chk("wait_rd", 32'(imem_rd), 32'h0);
            chk("wait_iv", 32'(instr_valid), 32'h0);
        end
        step();
        imem_valid = 1'b0;
        chk("hold_iv", 32'(instr_valid), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset       = 1'b1;
        imem_data   = 16'h0000;
        imem_valid  = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        // Outputs while reset is held
        step();
        step();
        chk("rst_rd", 32'(imem_rd), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_iv", 32'(instr_valid), 32'h0);
        chk("rst_opc", 32'(op_code), 32'h0);
        chk("rst_ops", 32'({op1, op2, op3}), 32'h0);
        chk("rst_imm", 32'(imm), 32'h0);

        // First fetch, latency 1: rd in cycle 0, instr_valid in cycle 2
        reset = 1'b0;
        #1;
        fetch(16'h0000, 16'h1234, 1);
        chk("a_opc", 32'(op_code), 32'h1);
        chk("a_op1", 32'(op1), 32'h2);
        chk("a_op2", 32'(op2), 32'h3);
        chk("a_op3", 32'(op3), 32'h4);
        chk("a_imm", 32'(imm), 32'h0002);
        chk("a_ipc", 32'(instr_pc), 32'h0000);
        step();

        // Reset mid-WAIT, then a late valid arriving in REQ is ignored
        chk("r_rd", 32'(imem_rd), 32'h1);
        chk("r_addr", 32'(imem_addr), 32'h0001);
        step();
        reset = 1'b1;
        #1;
        chk("r_rst_rd", 32'(imem_rd), 32'h0);
        chk("r_rst_addr", 32'(imem_addr), 32'h0);
        chk("r_rst_iv", 32'(instr_valid), 32'h0);
        step();
        reset      = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 16'hDEAD;
        #1;

        // Negative op1 sign-extends into imm
        fetch(16'h0000, 16'h3F21, 1);
        chk("b_opc", 32'(op_code), 32'h3);
        chk("b_op1", 32'(op1), 32'hF);
        chk("b_imm", 32'(imm), 32'hFFFF);
        chk("b_ipc", 32'(instr_pc), 32'h0000);
        step();

        // Backpressure: fields stay put, no read, stray imem_valid ignored
        instr_ready = 1'b0;
        fetch(16'h0001, 16'hA5C3, 2);
        for (int k = 0; k < 5; k++) begin
            chk("c_iv", 32'(instr_valid), 32'h1);
            chk("c_rd", 32'(imem_rd), 32'h0);
            chk("c_fields", 32'({op_code, op1, op2, op3}), 32'hA5C3);
            chk("c_imm", 32'(imm), 32'h0005);
            chk("c_ipc", 32'(instr_pc), 32'h0001);
            imem_valid = 1'b1;
            imem_data  = 16'h0BAD;
            step();
        end
        imem_valid  = 1'b0;
        instr_ready = 1'b1;
        chk("c_end_iv", 32'(instr_valid), 32'h1);
        chk("c_end_fields", 32'({op_code, op1, op2, op3}), 32'hA5C3);
        step();

        // Redirect during WAIT with latency 3: word dropped, refetch at target
        chk("d_rd", 32'(imem_rd), 32'h1);
        chk("d_addr", 32'(imem_addr), 32'h0002);
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        chk("d_w1_rd", 32'(imem_rd), 32'h0);
        step();
        redirect = 1'b0;
        chk("d_w2_iv", 32'(instr_valid), 32'h0);
        chk("d_w2_rd", 32'(imem_rd), 32'h0);
        step();
        imem_valid = 1'b1;
        imem_data  = 16'h9999;
        chk("d_w3_iv", 32'(instr_valid), 32'h0);
        step();
        imem_valid = 1'b0;
        chk("d_iv", 32'(instr_valid), 32'h0);
        fetch(16'h0040, 16'h5678, 1);
        chk("d_ipc", 32'(instr_pc), 32'h0040);
        chk("d_fields", 32'({op_code, op1, op2, op3}), 32'h5678);
        step();

        // Redirect coincident with imem_valid
        chk("e_addr", 32'(imem_addr), 32'h0041);
        step();
        imem_valid  = 1'b1;
        imem_data   = 16'h1111;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        chk("e_iv", 32'(instr_valid), 32'h0);
        step();
        imem_valid = 1'b0;
        redirect   = 1'b0;
        chk("e_post_iv", 32'(instr_valid), 32'h0);

        // Fetch at 0xFFFF then wrap to 0x0000
        fetch(16'hFFFF, 16'hE000, 1);
        chk("f_ipc", 32'(instr_pc), 32'hFFFF);
        chk("f_opc", 32'(op_code), 32'hE);
        step();
        instr_ready = 1'b0;
        fetch(16'h0000, 16'h2345, 1);
        chk("g_ipc", 32'(instr_pc), 32'h0000);
        chk("g_imm", 32'(imm), 32'h0003);

        // Redirect beats ready in HOLD
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0123;
        step();
        redirect = 1'b0;
        chk("g_rd", 32'(imem_rd), 32'h1);
        chk("g_addr", 32'(imem_addr), 32'h0123);
        chk("g_iv", 32'(instr_valid), 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
